// File: rtl/alpaca_pkg.sv
// Shared ALPACA FFT datapath types: complex sample, full-precision butterfly result, per-beat packets.
// Lane k of a packet is element [k]; re occupies the upper half of each sample.
package alpaca_pkg;

  localparam int WIDTH        = 16;
  localparam int PHASE_WIDTH  = 23;
  localparam int SAMP_PER_CLK = 2;
  localparam int ARITH_WIDTH  = PHASE_WIDTH + WIDTH + 1;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cx_t;

  typedef struct packed {
    logic signed [ARITH_WIDTH-1:0] re;
    logic signed [ARITH_WIDTH-1:0] im;
  } arith_t;

  typedef cx_t    [SAMP_PER_CLK-1:0] cx_pkt_t;
  typedef arith_t [SAMP_PER_CLK-1:0] arith_pkt_t;

endpackage

// File: rtl/alpaca_axis.sv
// AXI-stream style beat bundle used between ALPACA pipeline blocks.
// The payload is a flat vector; each endpoint views it through its own packed packet type.
interface alpaca_axis #(
  parameter int DW    = 64,
  parameter int TUSER = 16
);
  logic [DW-1:0]    tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [TUSER-1:0] tuser;

  modport mst (output tdata, tvalid, tlast, tuser, input tready);
  modport slv (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/alpaca_round_sat.sv
// Single-component requantizer, purely combinational: a round-half-up add on the input side, then shift
// and saturate on a separately supplied (registered) sum, so the parent can place a register between them.
module alpaca_round_sat
  import alpaca_pkg::*;
#(
  parameter int SHIFT = 22
) (
  input  logic signed [ARITH_WIDTH-1:0] i_v,
  output logic signed [ARITH_WIDTH:0]   o_sum,
  input  logic signed [ARITH_WIDTH:0]   i_sum,
  output logic signed [WIDTH-1:0]       o_q,
  output logic                          o_ovf
);

  localparam logic signed [ARITH_WIDTH:0] HALF =
    {{(ARITH_WIDTH+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [ARITH_WIDTH:0] MAX_W =
    {{(ARITH_WIDTH+2-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ARITH_WIDTH:0] MIN_W =
    {{(ARITH_WIDTH+2-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_Q = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_Q = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [ARITH_WIDTH:0] w_shr;

  // One extra bit of headroom so adding the half-LSB can never wrap.
  assign o_sum = $signed({i_v[ARITH_WIDTH-1], i_v}) + HALF;
  assign w_shr = i_sum >>> SHIFT;

  always_comb begin
    o_ovf = 1'b0;
    o_q   = w_shr[WIDTH-1:0];
    if (w_shr > MAX_W) begin
      o_ovf = 1'b1;
      o_q   = MAX_Q;
    end else if (w_shr < MIN_W) begin
      o_ovf = 1'b1;
      o_q   = MIN_Q;
    end
  end

endmodule

// File: rtl/alpaca_requant.sv
// Post-butterfly requantizer: round-half-up, drop SHIFT fraction bits, saturate to WIDTH; 2-cycle latency.
// Both stages advance only when y can accept or is empty; x.tready follows that enable combinationally.
module alpaca_requant
  import alpaca_pkg::*;
#(
  parameter int FFT_LEN = 16,
  parameter int SHIFT   = 22,
  parameter int TUSER   = 16
) (
  input  logic        clk,
  input  logic        rst,
  alpaca_axis.slv     x,
  alpaca_axis.mst     y,
  output logic        ovf,
  output logic        ovf_sticky,
  output logic [15:0] ovf_cnt,
  output logic        frame_err
);

  localparam int BEATS = FFT_LEN / SAMP_PER_CLK;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NC    = 2 * SAMP_PER_CLK;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  arith_pkt_t                    w_x_dat;
  cx_pkt_t                       w_y_dat;
  logic signed [ARITH_WIDTH-1:0] w_v     [NC];
  logic signed [ARITH_WIDTH:0]   w_sum   [NC];
  logic signed [WIDTH-1:0]       w_q     [NC];
  logic [NC-1:0]                 w_ovf;
  logic                          w_ce;
  logic                          w_acc;
  logic                          w_y_xfer;

  logic signed [ARITH_WIDTH:0]   r_p1_sum [NC];
  logic                          r_p1_vld;
  logic                          r_p1_last;
  logic [TUSER-1:0]              r_p1_user;
  logic                          r_y_vld;
  logic                          r_y_last;
  cx_pkt_t                       r_y_dat;
  logic [TUSER-1:0]              r_y_user;
  logic                          r_ovf;
  logic                          r_ovf_sticky;
  logic [15:0]                   r_ovf_cnt;
  logic                          r_frame_err;
  logic [CW-1:0]                 r_cnt;

  assign w_x_dat  = x.tdata;
  assign w_ce     = y.tready || !r_y_vld;
  assign w_acc    = x.tvalid && w_ce;
  assign w_y_xfer = r_y_vld && y.tready;

  genvar i;
  for (i = 0; i < SAMP_PER_CLK; i++) begin : g_lane
    assign w_v[2*i]   = w_x_dat[i].re;
    assign w_v[2*i+1] = w_x_dat[i].im;
  end

  for (i = 0; i < NC; i++) begin : g_rs
    alpaca_round_sat #(.SHIFT(SHIFT)) u_rs (
      .i_v   (w_v[i]),
      .o_sum (w_sum[i]),
      .i_sum (r_p1_sum[i]),
      .o_q   (w_q[i]),
      .o_ovf (w_ovf[i])
    );
  end

  always_comb begin
    w_y_dat = '0;
    for (int k = 0; k < SAMP_PER_CLK; k++) begin
      w_y_dat[k].re = w_q[2*k];
      w_y_dat[k].im = w_q[2*k+1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p1_vld  <= 1'b0;
      r_p1_last <= 1'b0;
      r_p1_user <= '0;
      for (int k = 0; k < NC; k++) r_p1_sum[k] <= '0;
      r_y_vld   <= 1'b0;
      r_y_last  <= 1'b0;
      r_y_dat   <= '0;
      r_y_user  <= '0;
      r_ovf     <= 1'b0;
    end else if (w_ce) begin
      r_p1_vld  <= x.tvalid;
      r_p1_last <= x.tlast;
      r_p1_user <= x.tuser;
      for (int k = 0; k < NC; k++) r_p1_sum[k] <= w_sum[k];
      r_y_vld   <= r_p1_vld;
      r_y_last  <= r_p1_last;
      r_y_dat   <= w_y_dat;
      r_y_user  <= r_p1_user;
      r_ovf     <= r_p1_vld && (|w_ovf);
    end
  end

  // An early tlast resynchronises the counter; a missing one still wraps it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else if (w_acc) begin
      if (x.tlast) begin
        if (r_cnt != LAST_BEAT) r_frame_err <= 1'b1;
        r_cnt <= '0;
      end else if (r_cnt == LAST_BEAT) begin
        r_frame_err <= 1'b1;
        r_cnt       <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_cnt    <= '0;
    end else if (w_y_xfer && r_ovf) begin
      r_ovf_sticky <= 1'b1;
      if (r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign x.tready   = w_ce;
  assign y.tvalid   = r_y_vld;
  assign y.tdata    = r_y_dat;
  assign y.tlast    = r_y_last;
  assign y.tuser    = r_y_user;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_ovf_sticky;
  assign ovf_cnt    = r_ovf_cnt;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_alpaca_requant.sv
// Directed bench for alpaca_requant: rounding, saturation, backpressure, framing, mid-stream reset,
// and ovf counter saturation, each with hand-computed expectations.
module tb_alpaca_requant;
  import alpaca_pkg::*;

  localparam longint P21 = 64'sd2097152;
  localparam longint P22 = 64'sd4194304;
  localparam longint P37 = 64'sd137438953472;
  localparam longint P38 = 64'sd274877906944;

  logic        clk;
  logic        rst;
  logic        ovf;
  logic        ovf_sticky;
  logic [15:0] ovf_cnt;
  logic        frame_err;
  int          checks = 0;
  int          errors = 0;

  alpaca_axis #(.DW($bits(arith_pkt_t)), .TUSER(16)) x_if ();
  alpaca_axis #(.DW($bits(cx_pkt_t)),    .TUSER(16)) y_if ();

  alpaca_requant #(.FFT_LEN(16), .SHIFT(22), .TUSER(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x_if),
    .y          (y_if),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_cnt    (ovf_cnt),
    .frame_err  (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic arith_pkt_t mk_a(input longint re0, input longint im0,
                                      input longint re1, input longint im1);
    arith_pkt_t p;
    p[0].re = 40'(re0);
    p[0].im = 40'(im0);
    p[1].re = 40'(re1);
    p[1].im = 40'(im1);
    return p;
  endfunction

  function automatic cx_pkt_t mk_c(input int re0, input int im0, input int re1, input int im1);
    cx_pkt_t p;
    p[0].re = 16'(re0);
    p[0].im = 16'(im0);
    p[1].re = 16'(re1);
    p[1].im = 16'(im1);
    return p;
  endfunction

  task automatic do_reset();
    rst         = 1'b0;
    x_if.tvalid = 1'b0;
    x_if.tlast  = 1'b0;
    x_if.tdata  = '0;
    x_if.tuser  = '0;
    y_if.tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic last);
    x_if.tvalid = 1'b1;
    x_if.tlast  = last;
    x_if.tdata  = '0;
    @(posedge clk);
    #1;
    x_if.tvalid = 1'b0;
    x_if.tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    x_if.tvalid = 1'b0;
    x_if.tlast  = 1'b0;
    x_if.tdata  = '0;
    x_if.tuser  = '0;
    y_if.tready = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (y_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", y_if.tvalid); end
    checks++; if (y_if.tdata !== 64'h0) begin errors++; $display("FAIL rst_tdata: got %h want 0", y_if.tdata); end
    checks++; if (y_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", y_if.tlast); end
    checks++; if (y_if.tuser !== 16'h0) begin errors++; $display("FAIL rst_tuser: got %h want 0", y_if.tuser); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %b want 0", ovf_sticky); end
    checks++; if (ovf_cnt !== 16'h0) begin errors++; $display("FAIL rst_ovf_cnt: got %h want 0", ovf_cnt); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    checks++; if (x_if.tready !== 1'b1) begin errors++; $display("FAIL rst_tready: got %b want 1", x_if.tready); end
    do_reset();
  endtask

  task automatic test_rounding();
    cx_pkt_t exp_c;
    do_reset();
    x_if.tvalid = 1'b1;
    x_if.tuser  = 16'h1234;
    x_if.tdata  = mk_a(3*P22 + P21, -P21, 3*P22 + P21 - 1, -3*P21);
    exp_c       = mk_c(4, 0, 3, -1);
    @(posedge clk);
    #1 x_if.tvalid = 1'b0;
    @(negedge clk);
    checks++; if (y_if.tvalid !== 1'b0) begin errors++; $display("FAIL round_early: tvalid got %b want 0", y_if.tvalid); end
    @(negedge clk);
    checks++; if (y_if.tvalid !== 1'b1) begin errors++; $display("FAIL round_latency: tvalid got %b want 1", y_if.tvalid); end
    checks++; if (y_if.tdata !== exp_c) begin errors++; $display("FAIL round_dat: got %h want %h", y_if.tdata, exp_c); end
    checks++; if (y_if.tuser !== 16'h1234) begin errors++; $display("FAIL round_tuser: got %h want 1234", y_if.tuser); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL round_ovf: got %b want 0", ovf); end
    @(negedge clk);
    checks++; if (y_if.tvalid !== 1'b0) begin errors++; $display("FAIL round_single: tvalid got %b want 0", y_if.tvalid); end
  endtask

  task automatic test_saturation();
    cx_pkt_t exp_c;
    do_reset();
    x_if.tvalid = 1'b1;
    x_if.tdata  = mk_a(0, -P38, P37, 0);
    @(posedge clk);
    #1 x_if.tdata = mk_a(P22, -P22, 2*P22, 0);
    @(posedge clk);
    #1 x_if.tvalid = 1'b0;
    @(negedge clk);
    exp_c = mk_c(0, -32768, 32767, 0);
    checks++; if (y_if.tdata !== exp_c) begin errors++; $display("FAIL sat_dat: got %h want %h", y_if.tdata, exp_c); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", ovf); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sat_sticky_pre: got %b want 0", ovf_sticky); end
    @(negedge clk);
    exp_c = mk_c(1, -1, 2, 0);
    checks++; if (y_if.tdata !== exp_c) begin errors++; $display("FAIL sat_clean_dat: got %h want %h", y_if.tdata, exp_c); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_clean_ovf: got %b want 0", ovf); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b want 1", ovf_sticky); end
    checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL sat_cnt: got %0d want 1", ovf_cnt); end
    @(negedge clk);
    checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL sat_cnt_hold: got %0d want 1", ovf_cnt); end
  endtask

  task automatic test_backpressure();
    int          sent = 0;
    int          rcv  = 0;
    logic        stalled = 1'b0;
    logic [63:0] held = '0;
    cx_pkt_t     exp_c;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      y_if.tready = !(c == 3 || c == 4 || c == 5 || c == 9);
      if (sent < 16) begin
        x_if.tvalid = 1'b1;
        x_if.tdata  = mk_a(sent*P22, -sent*P22, (sent+100)*P22, (2*sent+1)*P21);
        x_if.tlast  = (sent % 8 == 7);
        x_if.tuser  = 16'hdead;
      end else begin
        x_if.tvalid = 1'b0;
        x_if.tlast  = 1'b0;
      end
      @(negedge clk);
      if (stalled) begin
        checks++; if (y_if.tdata !== held) begin errors++; $display("FAIL bp_stable: got %h want %h", y_if.tdata, held); end
      end
      if (y_if.tvalid && y_if.tready) begin
        exp_c = mk_c(rcv, -rcv, rcv + 100, rcv + 1);
        checks++; if (y_if.tdata !== exp_c) begin errors++; $display("FAIL bp_dat[%0d]: got %h want %h", rcv, y_if.tdata, exp_c); end
        checks++; if (y_if.tuser !== 16'hdead) begin errors++; $display("FAIL bp_tuser[%0d]: got %h want dead", rcv, y_if.tuser); end
        checks++; if (y_if.tlast !== (rcv % 8 == 7)) begin errors++; $display("FAIL bp_tlast[%0d]: got %b want %b", rcv, y_if.tlast, (rcv % 8 == 7)); end
        rcv++;
      end
      stalled = y_if.tvalid && !y_if.tready;
      held    = y_if.tdata;
      if (x_if.tvalid && x_if.tready) sent++;
      @(posedge clk);
      #1;
    end
    y_if.tready = 1'b1;
    checks++; if (rcv != 16) begin errors++; $display("FAIL bp_count: got %0d beats want 16", rcv); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL bp_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_frame();
    do_reset();
    for (int i = 0; i < 16; i++) send_beat(i % 8 == 7);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_aligned: got %b want 0", frame_err); end
    for (int i = 0; i < 5; i++) send_beat(i == 4);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_early: got %b want 1", frame_err); end
    checks++; if (dut.r_cnt !== 3'd0) begin errors++; $display("FAIL frame_resync: cnt got %0d want 0", dut.r_cnt); end
    for (int i = 0; i < 3; i++) send_beat(1'b0);
    checks++; if (dut.r_cnt !== 3'd3) begin errors++; $display("FAIL frame_cnt3: cnt got %0d want 3", dut.r_cnt); end
    for (int i = 0; i < 5; i++) send_beat(i == 4);
    checks++; if (dut.r_cnt !== 3'd0) begin errors++; $display("FAIL frame_realign: cnt got %0d want 0", dut.r_cnt); end
    do_reset();
    for (int i = 0; i < 7; i++) send_beat(1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_pre_missing: got %b want 0", frame_err); end
    send_beat(1'b0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_missing: got %b want 1", frame_err); end
    checks++; if (dut.r_cnt !== 3'd0) begin errors++; $display("FAIL frame_missing_wrap: cnt got %0d want 0", dut.r_cnt); end
  endtask

  task automatic test_reset_midstream();
    cx_pkt_t exp_c;
    do_reset();
    x_if.tvalid = 1'b1;
    x_if.tuser  = 16'h0001;
    x_if.tdata  = mk_a(P37, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL mid_pre_cnt: got %0d want 1", ovf_cnt); end
    checks++; if (y_if.tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_vld: got %b want 1", y_if.tvalid); end
    rst         = 1'b0;
    x_if.tvalid = 1'b0;
    #1;
    checks++; if (y_if.tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b want 0", y_if.tvalid); end
    checks++; if (y_if.tdata !== 64'h0) begin errors++; $display("FAIL mid_tdata: got %h want 0", y_if.tdata); end
    checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL mid_ovf_cnt: got %0d want 0", ovf_cnt); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL mid_sticky: got %b want 0", ovf_sticky); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mid_frame_err: got %b want 0", frame_err); end
    checks++; if (dut.r_cnt !== 3'd0) begin errors++; $display("FAIL mid_beat_cnt: got %0d want 0", dut.r_cnt); end
    checks++; if (x_if.tready !== 1'b1) begin errors++; $display("FAIL mid_tready: got %b want 1", x_if.tready); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    x_if.tvalid = 1'b1;
    x_if.tuser  = 16'h0042;
    x_if.tdata  = mk_a(5*P22, -7*P22, P21, 0);
    exp_c       = mk_c(5, -7, 1, 0);
    @(posedge clk);
    #1 x_if.tvalid = 1'b0;
    @(negedge clk);
    checks++; if (y_if.tvalid !== 1'b0) begin errors++; $display("FAIL mid_post_early: tvalid got %b want 0", y_if.tvalid); end
    @(negedge clk);
    checks++; if (y_if.tvalid !== 1'b1) begin errors++; $display("FAIL mid_post_vld: got %b want 1", y_if.tvalid); end
    checks++; if (y_if.tdata !== exp_c) begin errors++; $display("FAIL mid_post_dat: got %h want %h", y_if.tdata, exp_c); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) send_beat(i == 6);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mid_post_frame: got %b want 0", frame_err); end
  endtask

  task automatic test_ovf_cnt_sat();
    do_reset();
    x_if.tvalid = 1'b1;
    x_if.tlast  = 1'b0;
    x_if.tdata  = mk_a(-P38, P38, -P38, P38);
    repeat (100) @(posedge clk);
    #1;
    checks++; if (ovf_cnt !== 16'd98) begin errors++; $display("FAIL cnt_98: got %0d want 98", ovf_cnt); end
    repeat (65441) @(posedge clk);
    #1;
    x_if.tvalid = 1'b0;
    checks++; if (ovf_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %h want ffff", ovf_cnt); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL cnt_sticky: got %b want 1", ovf_sticky); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (ovf_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_hold: got %h want ffff", ovf_cnt); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_frame();
    test_reset_midstream();
    test_ovf_cnt_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
